// File: rtl/rc_tdc_seq.sv
// Multi-channel RC charge-time measurement sequencer: times each channel's charge edge,
// averages 2^AVG_LOG2 samples, scales to resistance and hands results out over valid/ready.
module rc_tdc_seq #(
  parameter int          CHANNELS         = 4,
  parameter int          TIMEOUT          = 1000000,
  parameter int          DISCHARGE_CYCLES = 1000000,
  parameter int          AVG_LOG2         = 2,
  parameter logic [31:0] SCALE_Q16        = 32'd1890952,
  parameter int          RES_W            = 24,
  parameter int          CH_W             = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                mode_cont,
  input  logic [CHANNELS-1:0] step_in,
  output logic [CHANNELS-1:0] step_set,
  output logic                busy,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [RES_W-1:0]    res_data,
  output logic [CH_W-1:0]     res_chan,
  output logic                res_timeout
);

  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam int ACC_W  = CNT_W + AVG_LOG2;
  localparam int DIS_W  = $clog2(DISCHARGE_CYCLES + 1);
  localparam int TMR_W  = (CNT_W > DIS_W) ? CNT_W : DIS_W;
  localparam int SMP_W  = AVG_LOG2 + 1;
  localparam int PROD_W = ACC_W + 32;
  // One spare bit above both the product and RES_W+16 keeps the saturation test well-formed
  localparam int EXT_W  = ((PROD_W > RES_W + 16) ? PROD_W : RES_W + 16) + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHARGE = 3'd1;
  localparam logic [2:0] S_DISCH  = 3'd2;
  localparam logic [2:0] S_SCALE  = 3'd3;
  localparam logic [2:0] S_OUTPUT = 3'd4;

  localparam logic [TMR_W-1:0] CHG_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] DIS_LAST = TMR_W'(DISCHARGE_CYCLES - 1);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((1 << AVG_LOG2) - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);

  logic [2:0]          state;
  logic [CH_W-1:0]     ch;
  logic [TMR_W-1:0]    tmr;
  logic [CNT_W-1:0]    sample;
  logic [ACC_W-1:0]    acc;
  logic [SMP_W-1:0]    samples;
  logic                tflag;
  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync2;

  logic [ACC_W-1:0] avg;
  logic [EXT_W-1:0] prod;
  logic [EXT_W-1:0] scaled;
  logic             sat;

  always_comb begin
    avg    = acc >> AVG_LOG2;
    prod   = EXT_W'(avg) * EXT_W'(SCALE_Q16);
    scaled = prod >> 16;
    sat    = (scaled >> RES_W) != '0;
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ch          <= '0;
      tmr         <= '0;
      sample      <= '0;
      acc         <= '0;
      samples     <= '0;
      tflag       <= 1'b0;
      sync1       <= '0;
      sync2       <= '0;
      step_set    <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_chan    <= '0;
      res_timeout <= 1'b0;
    end else begin
      sync1 <= step_in;
      sync2 <= sync1;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_CHARGE;
            ch       <= '0;
            acc      <= '0;
            samples  <= '0;
            tflag    <= 1'b0;
            tmr      <= '0;
            step_set <= CHANNELS'(1);
          end
        end
        S_CHARGE: begin
          // Comparator edge wins over a timeout landing on the same cycle
          if (sync2[ch]) begin
            sample   <= CNT_W'(tmr);
            tmr      <= '0;
            step_set <= '0;
            state    <= S_DISCH;
          end else if (tmr == CHG_LAST) begin
            sample   <= CNT_W'(TIMEOUT);
            tflag    <= 1'b1;
            tmr      <= '0;
            step_set <= '0;
            state    <= S_DISCH;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_DISCH: begin
          if (tmr >= DIS_LAST && !sync2[ch]) begin
            acc     <= acc + ACC_W'(sample);
            samples <= samples + 1'b1;
            tmr     <= '0;
            if (samples == SMP_LAST) begin
              state <= S_SCALE;
            end else begin
              state    <= S_CHARGE;
              step_set <= CHANNELS'(1) << ch;
            end
          end else if (tmr < DIS_LAST) begin
            tmr <= tmr + 1'b1;
          end
        end
        S_SCALE: begin
          res_data    <= (tflag || sat) ? '1 : scaled[RES_W-1:0];
          res_chan    <= ch;
          res_timeout <= tflag;
          res_valid   <= 1'b1;
          state       <= S_OUTPUT;
        end
        S_OUTPUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            acc       <= '0;
            samples   <= '0;
            tflag     <= 1'b0;
            tmr       <= '0;
            if (ch == CH_LAST) begin
              ch <= '0;
              if (mode_cont) begin
                state    <= S_CHARGE;
                step_set <= CHANNELS'(1);
              end else begin
                state <= S_IDLE;
              end
            end else begin
              ch       <= ch + 1'b1;
              state    <= S_CHARGE;
              step_set <= CHANNELS'(1) << (ch + 1'b1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc_tdc_seq.sv
// Randomised bench for rc_tdc_seq: an RC responder model predicts each channel's result,
// a monitor pops predictions on every res_valid/res_ready handshake.
module tb_rc_tdc_seq;
  localparam int     CH    = 4;
  localparam int     TO    = 200;
  localparam int     DC    = 50;
  localparam int     AVG   = 2;
  localparam int     RW    = 12;
  localparam int     CW    = 2;
  localparam longint SCALE = 1890952;
  localparam longint RMAX  = (64'd1 << RW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          mode_cont = 1'b0;
  logic          res_ready = 1'b0;
  logic [CH-1:0] step_in = '0;
  logic [CH-1:0] step_set;
  logic          busy, res_valid, res_timeout;
  logic [RW-1:0] res_data;
  logic [CW-1:0] res_chan;

  rc_tdc_seq #(
    .CHANNELS(CH), .TIMEOUT(TO), .DISCHARGE_CYCLES(DC), .AVG_LOG2(AVG),
    .SCALE_Q16(32'd1890952), .RES_W(RW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_cont(mode_cont),
    .step_in(step_in), .step_set(step_set), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_chan(res_chan), .res_timeout(res_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  typedef struct {
    int     ch;
    longint data;
    bit     tout;
  } res_t;
  res_t exp_q[$];

  // RC network model: comparator trips d cycles after excitation; each channel's
  // result is predicted from the sample values the timing rules imply.
  bit     charging = 1'b0;
  bit     first = 1'b1;
  int     cur = 0, k = 0, d = 0, hold = 0, gap = 0;
  int     exp_ch = 0, nsmp = 0;
  longint sum = 0;
  bit     tf = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      charging = 1'b0; first = 1'b1; hold = 0; gap = 0;
      exp_ch = 0; nsmp = 0; sum = 0; tf = 1'b0;
      step_in = '0;
      exp_q.delete();
    end else begin
      if (!charging) begin
        if (hold > 0) hold--;
        else step_in = '0;
        if (step_set != '0) begin
          for (int i = CH - 1; i >= 0; i--) if (step_set[i]) cur = i;
          check("charge_channel", cur, exp_ch);
          if (!first) check("discharge_gap_ok", longint'(gap >= DC), 1);
          first = 1'b0; charging = 1'b1; k = 0;
          d = ($urandom_range(0, 7) == 0) ? 1000 : int'($urandom_range(0, 205));
        end else begin
          gap++;
        end
      end
      if (charging) begin
        if (step_set[cur]) begin
          check("step_set_onehot", step_set, longint'(1) << cur);
          if (k == d) step_in[cur] = 1'b1;
          k++;
        end else begin
          int  smp;
          bit  tout;
          res_t e;
          tout = (d + 2 > TO - 1);
          smp  = tout ? TO : d + 2;
          check("charge_length", k, tout ? TO : smp + 1);
          check("step_set_off_in_discharge", step_set, 0);
          charging = 1'b0; gap = 1; hold = $urandom_range(0, 80);
          sum += smp; tf |= tout; nsmp++;
          if (nsmp == (1 << AVG)) begin
            longint r;
            r = ((sum >> AVG) * SCALE) >> 16;
            if (tf || r > RMAX) r = RMAX;
            e.ch = exp_ch; e.data = r; e.tout = tf;
            exp_q.push_back(e);
            nsmp = 0; sum = 0; tf = 1'b0;
            exp_ch = (exp_ch + 1) % CH;
          end
        end
      end
    end
  end

  // Monitor: drives res_ready, compares at each handshake, checks hold under stall
  int   ready_mode = 0;
  int   n_res = 0;
  bit   pend = 1'b0, hs_prev = 1'b0;
  res_t held;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0; hs_prev = 1'b0; res_ready = 1'b0;
    end else begin
      if (hs_prev) check("valid_clears_after_handshake", res_valid, 0);
      hs_prev = 1'b0;
      if (res_valid && pend) begin
        check("stall_data_stable", res_data, held.data);
        check("stall_chan_stable", res_chan, held.ch);
        check("stall_tout_stable", res_timeout, held.tout);
      end
      case (ready_mode)
        0:       res_ready = ($urandom_range(0, 3) != 0);
        1:       res_ready = 1'b0;
        default: res_ready = 1'b1;
      endcase
      if (res_valid) begin
        if (res_ready) begin
          check("result_predicted", longint'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            res_t e;
            e = exp_q.pop_front();
            check("res_data", res_data, e.data);
            check("res_chan", res_chan, e.ch);
            check("res_timeout", res_timeout, e.tout);
          end
          n_res++; hs_prev = 1'b1; pend = 1'b0;
        end else begin
          pend = 1'b1;
          held.data = res_data; held.ch = res_chan; held.tout = res_timeout;
        end
      end
    end
  end

  task automatic pulse_start(input bit cont);
    mode_cont = cont;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 20000 && busy; i++) @(negedge clk);
    check(name, busy, 0);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20000 && !res_valid; i++) @(negedge clk);
    check("wait_res_valid", res_valid, 1);
  endtask

  task automatic async_reset(input string name);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check({name, "_step_set"}, step_set, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_res_valid"}, res_valid, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check({name, "_idle_until_start"}, busy, 0);
    check({name, "_no_excitation"}, step_set, 0);
  endtask

  initial begin
    int base;
    repeat (3) @(negedge clk);
    check("reset_step_set", step_set, 0);
    check("reset_busy", busy, 0);
    check("reset_res_valid", res_valid, 0);
    check("reset_res_data", res_data, 0);
    check("reset_res_chan", res_chan, 0);
    check("reset_res_timeout", res_timeout, 0);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_without_start", busy, 0);

    // Single sweep, with a stray start mid-sweep that must be ignored
    base = n_res;
    pulse_start(1'b0);
    repeat (300) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("sweep1_ends");
    check("sweep1_results", n_res - base, 4);

    // Backpressure: consumer stalls 30 cycles on the first result
    base = n_res;
    ready_mode = 1;
    pulse_start(1'b0);
    wait_valid();
    repeat (30) begin
      @(negedge clk);
      check("stall_valid_held", res_valid, 1);
      check("stall_no_charge", step_set, 0);
    end
    ready_mode = 0;
    wait_idle("sweep2_ends");
    check("sweep2_results", n_res - base, 4);

    // Continuous mode wraps without start; dropping mode_cont stops at the next wrap
    base = n_res;
    pulse_start(1'b1);
    for (int i = 0; i < 40000 && (n_res - base) < 6; i++) @(negedge clk);
    check("cont_past_wrap", longint'((n_res - base) >= 6), 1);
    mode_cont = 1'b0;
    wait_idle("cont_stops");
    check("cont_results", n_res - base, 8);

    // Reset mid-CHARGE
    pulse_start(1'b0);
    for (int i = 0; i < 1000 && step_set == '0; i++) @(negedge clk);
    check("charging_before_reset", longint'(step_set != '0), 1);
    repeat (5) @(negedge clk);
    async_reset("rst_charge");

    // Reset mid-OUTPUT
    ready_mode = 1;
    pulse_start(1'b0);
    wait_valid();
    async_reset("rst_output");
    ready_mode = 0;

    // Normal operation after reset
    base = n_res;
    pulse_start(1'b0);
    wait_idle("sweep_after_reset_ends");
    check("sweep_after_reset_results", n_res - base, 4);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
